// File: rtl/reg_shift_unit_if.sv
// Command/result bundle between the sequencer, the shifter and the
// general register's data buses.
interface reg_shift_unit_if #(
   parameter int WIDTH = 256,
   parameter int AMT_W = 8
);
   logic [WIDTH-1:0] OperandIn;
   logic [AMT_W-1:0] ShiftAmt;
   logic [1:0]       ShiftOp;
   logic             Start;
   logic             Ack;
   logic [WIDTH-1:0] ResultOut;
   logic             Done;
   logic             Busy;

   modport master (
      output OperandIn, ShiftAmt, ShiftOp, Start, Ack,
      input  ResultOut, Done, Busy
   );

   modport slave (
      input  OperandIn, ShiftAmt, ShiftOp, Start, Ack,
      output ResultOut, Done, Busy
   );
endinterface

// File: rtl/reg_shift_unit.sv
// Multi-cycle LSL/LSR/ASR/ROL shifter, at most STEP positions per clock,
// sitting between the general register's data-out and data-in buses.
module reg_shift_unit #(
   parameter int WIDTH = 256,
   parameter int STEP  = 8,
   parameter int AMT_W = 8
) (
   input logic            clk,
   input logic            reset,
   reg_shift_unit_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] OP_LSL = 2'b00;
   localparam logic [1:0] OP_LSR = 2'b01;
   localparam logic [1:0] OP_ASR = 2'b10;
   localparam logic [1:0] OP_ROL = 2'b11;

   localparam logic [AMT_W:0] STEP_N = (AMT_W+1)'(STEP);
   localparam logic [AMT_W:0] WIDTH_N = (AMT_W+1)'(WIDTH);

   state_t           state, state_n;
   logic [WIDTH-1:0] work, work_n;
   logic [AMT_W-1:0] remaining, rem_n;
   logic [1:0]       op, op_n;
   logic             sign, sign_n;

   logic [AMT_W:0]   rem_x;
   logic [AMT_W:0]   step_n;
   logic [AMT_W:0]   wrap_n;
   logic [WIDTH-1:0] fill;
   logic [WIDTH-1:0] shifted;

   assign rem_x  = {1'b0, remaining};
   assign step_n = (rem_x < STEP_N) ? rem_x : STEP_N;
   assign wrap_n = WIDTH_N - step_n;
   // ASR fill comes from the sign captured at Start, not from work
   assign fill   = sign ? ~({WIDTH{1'b1}} >> step_n) : '0;

   always_comb begin
      shifted = work;
      unique case (op)
         OP_LSL: shifted = work << step_n;
         OP_LSR: shifted = work >> step_n;
         OP_ASR: shifted = (work >> step_n) | fill;
         OP_ROL: shifted = (work << step_n) | (work >> wrap_n);
         default: shifted = work;
      endcase
   end

   always_comb begin
      state_n = state;
      work_n  = work;
      rem_n   = remaining;
      op_n    = op;
      sign_n  = sign;
      unique case (state)
         IDLE: begin
            if (bus.Start) begin
               work_n  = bus.OperandIn;
               rem_n   = bus.ShiftAmt;
               op_n    = bus.ShiftOp;
               sign_n  = bus.OperandIn[WIDTH-1];
               state_n = (bus.ShiftAmt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            work_n = shifted;
            rem_n  = remaining - step_n[AMT_W-1:0];
            if (rem_n == '0) state_n = DONE;
         end
         DONE: begin
            if (bus.Ack) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         work      <= '0;
         remaining <= '0;
         op        <= OP_LSL;
         sign      <= 1'b0;
      end else begin
         state     <= state_n;
         work      <= work_n;
         remaining <= rem_n;
         op        <= op_n;
         sign      <= sign_n;
      end
   end

   assign bus.ResultOut = work;
   assign bus.Done      = (state == DONE);
   assign bus.Busy      = (state != IDLE);
endmodule

// File: tb/tb_reg_shift_unit.sv
// Directed bench for reg_shift_unit: shift results, SHIFT-edge latency,
// handshake corner cases and reset abort.
module tb_reg_shift_unit;
   localparam int W = 256;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   edges;

   reg_shift_unit_if #(.WIDTH(W), .AMT_W(8)) bus ();

   reg_shift_unit #(.WIDTH(W), .STEP(8), .AMT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input string tag, input logic [W-1:0] opnd,
                      input logic [7:0] amt, input logic [1:0] op,
                      input logic [W-1:0] exp, input int exp_edges);
      bus.OperandIn = opnd;
      bus.ShiftAmt  = amt;
      bus.ShiftOp   = op;
      bus.Start     = 1'b1;
      tick();
      bus.Start     = 1'b0;
      bus.OperandIn = ~opnd;
      bus.ShiftAmt  = amt + 8'd3;
      bus.ShiftOp   = ~op;
      chk({tag, "_busy"}, W'(bus.Busy), W'(1));
      edges = 0;
      while (!bus.Done && edges < 100) begin
         tick();
         edges++;
      end
      chk({tag, "_edges"}, W'(edges), W'(exp_edges));
      chk({tag, "_res"}, bus.ResultOut, exp);
      tick();
      chk({tag, "_hold"}, bus.ResultOut, exp);
      chk({tag, "_hold_done"}, W'(bus.Done), W'(1));
      bus.Ack = 1'b1;
      tick();
      bus.Ack = 1'b0;
      chk({tag, "_ack_done"}, W'(bus.Done), W'(0));
      chk({tag, "_ack_busy"}, W'(bus.Busy), W'(0));
      chk({tag, "_ack_res"}, bus.ResultOut, exp);
   endtask

   initial begin
      bus.OperandIn = {W{1'b1}};
      bus.ShiftAmt  = 8'd5;
      bus.ShiftOp   = 2'b00;
      bus.Start     = 1'b1;
      bus.Ack       = 1'b0;
      reset         = 1'b0;
      tick();
      chk("rst_res", bus.ResultOut, '0);
      chk("rst_done", W'(bus.Done), W'(0));
      chk("rst_busy", W'(bus.Busy), W'(0));
      bus.Start = 1'b0;
      reset     = 1'b1;
      tick();
      tick();
      chk("idle_busy", W'(bus.Busy), W'(0));
      chk("idle_res", bus.ResultOut, '0);

      run("lsl8", 256'hAA, 8'd8, 2'b00, 256'hAA00, 1);
      run("lsl248", 256'hAA, 8'd248, 2'b00, {8'hAA, 248'h0}, 31);
      run("asr4", {1'b1, 255'h0}, 8'd4, 2'b10, {5'b11111, 251'h0}, 1);
      run("lsr4", {1'b1, 255'h0}, 8'd4, 2'b01, {5'b00001, 251'h0}, 1);
      run("rol20", 256'hAA, 8'd20, 2'b11, 256'hAA00000, 3);
      run("rol4", {8'hF0, 240'h0, 8'hF0}, 8'd4, 2'b11, 256'hF0F, 1);
      run("amt0", 256'h1234, 8'd0, 2'b01, 256'h1234, 0);

      // Start held through SHIFT, then Start+Ack together in DONE
      bus.OperandIn = 256'hFF000;
      bus.ShiftAmt  = 8'd12;
      bus.ShiftOp   = 2'b01;
      bus.Start     = 1'b1;
      tick();
      bus.OperandIn = 256'h55;
      bus.ShiftAmt  = 8'd0;
      bus.ShiftOp   = 2'b00;
      edges = 0;
      while (!bus.Done && edges < 100) begin
         tick();
         edges++;
      end
      chk("sdur_edges", W'(edges), W'(2));
      chk("sdur_res", bus.ResultOut, 256'hFF);
      bus.Ack = 1'b1;
      tick();
      bus.Ack   = 1'b0;
      bus.Start = 1'b0;
      chk("sack_busy", W'(bus.Busy), W'(0));
      chk("sack_done", W'(bus.Done), W'(0));
      tick();
      chk("sack_idle", W'(bus.Busy), W'(0));
      chk("sack_res", bus.ResultOut, 256'hFF);

      // Reset in the middle of a long shift
      bus.OperandIn = 256'hDEAD;
      bus.ShiftAmt  = 8'd200;
      bus.ShiftOp   = 2'b00;
      bus.Start     = 1'b1;
      tick();
      bus.Start = 1'b0;
      tick();
      tick();
      chk("mid_busy", W'(bus.Busy), W'(1));
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("mid_rst_res", bus.ResultOut, '0);
      chk("mid_rst_done", W'(bus.Done), W'(0));
      chk("mid_rst_busy", W'(bus.Busy), W'(0));
      tick();
      chk("mid_rst_idle", W'(bus.Busy), W'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
